// File: rtl/matrix_hostfifo_rec.sv
// Record FIFO between the RX decoder and the host: records are built speculatively,
// prefixed with a header word on commit, and only whole committed records are readable.
module matrix_hostfifo_rec #(
  parameter int DW  = 32,
  parameter int AW  = 6,
  parameter int RCW = 4
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            wr_Start,
  input  logic [DW-1:0]   wr_Data,
  input  logic            wr_Load,
  input  logic            wr_End,
  input  logic            wr_Abort,
  input  logic            wr_Type,
  input  logic [10:0]     wr_BitLen,
  input  logic            fifoRead,
  output logic [DW-1:0]   fifoDataOut,
  output logic            fifoValid,
  output logic            fifoHdr,
  output logic            fifoEmpty,
  output logic [RCW-1:0]  fifoRecCnt,
  output logic [AW:0]     fifoFree,
  output logic            fifoOvf,
  output logic            fifoErr,
  input  logic            fifoClrSticky
);

  localparam int             DEPTH   = 1 << AW;
  localparam logic [AW:0]    DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [RCW-1:0] REC_MAX = '1;

  typedef enum logic [1:0] {IDLE, OPEN, DROP} wrState_t;

  wrState_t      wrState;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   rdPtr, cmPtr, wp, hdrPtr;
  logic [15:0]   wordCnt, remWords;
  logic          expectHdr;

  logic [AW:0]   freeWp, startBase, startFree, wpAfterLoad;
  logic [15:0]   cntAfterLoad;
  logic          canOpen, spaceFull, inOpen, loadOk, loadOvf, commit;
  logic          pop, popLast;
  logic [DW-1:0] hdrWord, rdWord;

  // A start while a record is open first rolls the open record back, so the
  // space check for the new record is made from the header slot, not from wp.
  assign freeWp       = DEPTH_P - (wp - rdPtr);
  assign startBase    = (wrState == OPEN) ? hdrPtr : wp;
  assign startFree    = DEPTH_P - (startBase - rdPtr);
  assign canOpen      = (startFree != '0) && (fifoRecCnt != REC_MAX);
  assign spaceFull    = (freeWp == '0);
  assign inOpen       = (wrState == OPEN) && !wr_Start && !wr_Abort;
  assign loadOk       = inOpen && wr_Load && !spaceFull;
  assign loadOvf      = inOpen && wr_Load && spaceFull;
  assign commit       = inOpen && wr_End && !loadOvf;
  assign wpAfterLoad  = wp + (AW+1)'(loadOk);
  assign cntAfterLoad = wordCnt + 16'(loadOk);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hdrWord        = '0;
    hdrWord[31]    = wr_Type;
    hdrWord[26:16] = wr_BitLen;
    hdrWord[15:0]  = cntAfterLoad;
  end

  assign fifoFree  = freeWp;
  assign fifoEmpty = (rdPtr == cmPtr);
  assign pop       = fifoRead && !fifoEmpty;
  assign rdWord    = mem[rdPtr[AW-1:0]];
  assign popLast   = pop && (expectHdr ? (rdWord[15:0] == 16'd0) : (remWords == 16'd1));

  // NOTE: the storage array has no reset; its contents are only meaningful behind cmPtr.
  always_ff @(posedge Clk) begin
    if (loadOk) mem[wp[AW-1:0]] <= wr_Data;
    if (commit) mem[hdrPtr[AW-1:0]] <= hdrWord;
  end

  // Write FSM. Sticky sets are assigned after the clear so a same-cycle set wins.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wrState <= IDLE;
      wp      <= '0;
      hdrPtr  <= '0;
      cmPtr   <= '0;
      wordCnt <= '0;
      fifoOvf <= 1'b0;
      fifoErr <= 1'b0;
    end else begin
      if (fifoClrSticky) begin
        fifoOvf <= 1'b0;
        fifoErr <= 1'b0;
      end
      if (wr_Start) begin
        if (wrState != IDLE) fifoErr <= 1'b1;
        if (canOpen) begin
          hdrPtr  <= startBase;
          wp      <= startBase + 1'b1;
          wordCnt <= '0;
          wrState <= OPEN;
        end else begin
          wp      <= startBase;
          wrState <= DROP;
        end
      end else begin
        unique case (wrState)
          OPEN: begin
            if (wr_Abort) begin
              wp      <= hdrPtr;
              wrState <= IDLE;
            end else if (loadOvf) begin
              wp      <= hdrPtr;
              fifoOvf <= 1'b1;
              wrState <= wr_End ? IDLE : DROP;
            end else begin
              if (loadOk) begin
                wp      <= wpAfterLoad;
                wordCnt <= cntAfterLoad;
              end
              if (wr_End) begin
                cmPtr   <= wpAfterLoad;
                wrState <= IDLE;
              end
            end
          end
          DROP: begin
            if (wr_Abort) begin
              wrState <= IDLE;
            end else if (wr_End) begin
              fifoOvf <= 1'b1;
              wrState <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read side: the tracker knows whether the next pop is a header and how many
  // data words of the current record remain.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdPtr       <= '0;
      expectHdr   <= 1'b1;
      remWords    <= '0;
      fifoDataOut <= '0;
      fifoValid   <= 1'b0;
      fifoHdr     <= 1'b0;
      fifoRecCnt  <= '0;
    end else begin
      fifoValid <= pop;
      fifoHdr   <= pop && expectHdr;
      if (pop) begin
        fifoDataOut <= rdWord;
        rdPtr       <= rdPtr + 1'b1;
        if (expectHdr) begin
          remWords  <= rdWord[15:0];
          expectHdr <= (rdWord[15:0] == 16'd0);
        end else begin
          remWords  <= remWords - 1'b1;
          expectHdr <= (remWords == 16'd1);
        end
      end
      unique case ({commit, popLast})
        2'b10:   fifoRecCnt <= fifoRecCnt + 1'b1;
        2'b01:   fifoRecCnt <= fifoRecCnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_hostfifo_rec.sv
// Bench for matrix_hostfifo_rec: a queue-based record model is stepped every clock
// and every output is compared against it, plus literal checks on directed scenarios.
module tb_matrix_hostfifo_rec;

  localparam int DEPTH   = 64;
  localparam int REC_MAX = 15;

  logic        Clk, Reset_n;
  logic        wr_Start, wr_Load, wr_End, wr_Abort, wr_Type;
  logic [31:0] wr_Data;
  logic [10:0] wr_BitLen;
  logic        fifoRead, fifoClrSticky;
  logic [31:0] fifoDataOut;
  logic        fifoValid, fifoHdr, fifoEmpty, fifoOvf, fifoErr;
  logic [3:0]  fifoRecCnt;
  logic [6:0]  fifoFree;

  matrix_hostfifo_rec dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_Start(wr_Start), .wr_Data(wr_Data), .wr_Load(wr_Load), .wr_End(wr_End),
    .wr_Abort(wr_Abort), .wr_Type(wr_Type), .wr_BitLen(wr_BitLen),
    .fifoRead(fifoRead), .fifoDataOut(fifoDataOut), .fifoValid(fifoValid),
    .fifoHdr(fifoHdr), .fifoEmpty(fifoEmpty), .fifoRecCnt(fifoRecCnt),
    .fifoFree(fifoFree), .fifoOvf(fifoOvf), .fifoErr(fifoErr),
    .fifoClrSticky(fifoClrSticky)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    bit          hdr;
    bit          last;
  } word_t;
  typedef enum {M_IDLE, M_OPEN, M_DROP} mode_t;

  word_t       mq[$];
  logic [31:0] ob[$];
  mode_t       mode;
  bit          mOvf, mErr, mValid, mHdr;
  logic [31:0] mData;
  int          nTests, nFail, maxRec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int recsPending();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  function automatic int occupancy();
    return mq.size() + ((mode == M_OPEN) ? 1 + ob.size() : 0);
  endfunction

  task automatic modelReset();
    mq.delete();
    ob.delete();
    mode   = M_IDLE;
    mOvf   = 0;
    mErr   = 0;
    mValid = 0;
    mHdr   = 0;
    mData  = '0;
  endtask

  // One clock of the specification's behaviour, from the inputs held this cycle.
  task automatic modelStep();
    int          preSize = mq.size();
    int          preRec  = recsPending();
    int          openOcc = (mode == M_OPEN) ? 1 + ob.size() : 0;
    bit          ovfSet  = 0;
    bit          errSet  = 0;
    word_t       w;
    logic [31:0] h;
    mValid = 0;
    mHdr   = 0;
    if (fifoRead && preSize > 0) begin
      w      = mq.pop_front();
      mValid = 1;
      mHdr   = w.hdr;
      mData  = w.data;
    end
    if (wr_Start) begin
      if (mode != M_IDLE) errSet = 1;
      ob.delete();
      mode = (DEPTH - preSize >= 1 && preRec < REC_MAX) ? M_OPEN : M_DROP;
    end else if (mode == M_OPEN) begin
      if (wr_Abort) begin
        ob.delete();
        mode = M_IDLE;
      end else if (wr_Load && (DEPTH - preSize - openOcc == 0)) begin
        ovfSet = 1;
        ob.delete();
        mode = wr_End ? M_IDLE : M_DROP;
      end else begin
        if (wr_Load) ob.push_back(wr_Data);
        if (wr_End) begin
          h = {wr_Type, 4'b0000, wr_BitLen, 16'(ob.size())};
          mq.push_back('{data: h, hdr: 1, last: (ob.size() == 0)});
          foreach (ob[i]) mq.push_back('{data: ob[i], hdr: 0, last: (i == ob.size() - 1)});
          ob.delete();
          mode = M_IDLE;
        end
      end
    end else if (mode == M_DROP) begin
      if (wr_Abort) mode = M_IDLE;
      else if (wr_End) begin
        ovfSet = 1;
        mode   = M_IDLE;
      end
    end
    mOvf = ovfSet ? 1'b1 : (fifoClrSticky ? 1'b0 : mOvf);
    mErr = errSet ? 1'b1 : (fifoClrSticky ? 1'b0 : mErr);
  endtask

  task automatic compareAll();
    check("dataOut", fifoDataOut, mData);
    check("valid", fifoValid, mValid);
    check("hdr", fifoHdr, mHdr);
    check("empty", fifoEmpty, mq.size() == 0);
    check("recCnt", fifoRecCnt, recsPending());
    check("free", fifoFree, DEPTH - occupancy());
    check("ovf", fifoOvf, mOvf);
    check("err", fifoErr, mErr);
    if (int'(fifoRecCnt) > maxRec) maxRec = int'(fifoRecCnt);
  endtask

  task automatic cycle();
    @(posedge Clk);
    modelStep();
    @(negedge Clk);
    compareAll();
  endtask

  task automatic clearInputs();
    wr_Start = 0; wr_Load = 0; wr_End = 0; wr_Abort = 0; wr_Type = 0;
    wr_Data = '0; wr_BitLen = '0; fifoRead = 0; fifoClrSticky = 0;
  endtask

  task automatic op(input bit s, input bit l, input logic [31:0] d, input bit e,
                    input bit a, input bit t, input logic [10:0] len, input bit rd);
    wr_Start = s; wr_Load = l; wr_Data = d; wr_End = e; wr_Abort = a;
    wr_Type = t; wr_BitLen = len; fifoRead = rd;
    cycle();
    clearInputs();
  endtask

  task automatic doStart(input bit rd = 0);                  op(1, 0, '0, 0, 0, 0, '0, rd); endtask
  task automatic doLoad(input logic [31:0] d, input bit rd = 0); op(0, 1, d, 0, 0, 0, '0, rd); endtask
  task automatic doEnd(input bit t, input logic [10:0] len); op(0, 0, '0, 1, 0, t, len, 0); endtask
  task automatic doAbort();                                  op(0, 0, '0, 0, 1, 0, '0, 0); endtask
  task automatic doPop();                                    op(0, 0, '0, 0, 0, 0, '0, 1); endtask
  task automatic doClr();
    fifoClrSticky = 1;
    cycle();
    clearInputs();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".dataOut"}, fifoDataOut, 32'h0);
    check({tag, ".valid"}, fifoValid, 1'b0);
    check({tag, ".hdr"}, fifoHdr, 1'b0);
    check({tag, ".empty"}, fifoEmpty, 1'b1);
    check({tag, ".recCnt"}, fifoRecCnt, 4'd0);
    check({tag, ".free"}, fifoFree, 7'd64);
    check({tag, ".ovf"}, fifoOvf, 1'b0);
    check({tag, ".err"}, fifoErr, 1'b0);
  endtask

  initial begin
    int readPct;
    int r;
    nTests = 0;
    nFail  = 0;
    maxRec = 0;
    clearInputs();
    modelReset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checkResetOutputs("reset");
    Reset_n = 1'b1;

    // Single two-word record.
    doStart();
    doLoad(32'hA5A5A5A5);
    doLoad(32'h5A5A5A5A);
    doEnd(0, 11'd16);
    check("t1.recCnt", fifoRecCnt, 4'd1);
    doPop();
    check("t1.hdrWord", fifoDataOut, 32'h00100002);
    check("t1.hdrFlag", fifoHdr, 1'b1);
    doPop();
    check("t1.word0", fifoDataOut, 32'hA5A5A5A5);
    doPop();
    check("t1.word1", fifoDataOut, 32'h5A5A5A5A);
    check("t1.recDone", fifoRecCnt, 4'd0);
    check("t1.empty", fifoEmpty, 1'b1);

    // Aborted record followed by a committed one.
    doStart();
    repeat (3) doLoad($urandom);
    doAbort();
    check("t2.freeAfterAbort", fifoFree, 7'd64);
    doStart();
    doLoad(32'h12345678);
    doEnd(1, 11'd128);
    doPop();
    check("t2.hdrWord", fifoDataOut, 32'h80800001);
    doPop();
    check("t2.word", fifoDataOut, 32'h12345678);
    check("t2.free", fifoFree, 7'd64);

    // Record larger than the store: last load overflows and the End commits nothing.
    doStart();
    for (int i = 0; i < DEPTH - 1; i++) doLoad(i);
    check("t3.full", fifoFree, 7'd0);
    doLoad(32'hDEAD0000);
    check("t3.ovf", fifoOvf, 1'b1);
    check("t3.freeRolled", fifoFree, 7'd64);
    doLoad(32'hDEAD0001);
    check("t3.dropLoad", fifoFree, 7'd64);
    doEnd(0, 11'd3);
    check("t3.recCnt", fifoRecCnt, 4'd0);
    check("t3.free", fifoFree, 7'd64);
    doClr();
    check("t3.ovfClr", fifoOvf, 1'b0);

    // Seven-word records with the host reading every cycle, across the pointer wrap.
    maxRec = 0;
    for (int k = 0; k < 20; k++) begin
      doStart(1);
      for (int j = 0; j < 5; j++) doLoad({k[15:0], j[15:0]}, 1);
      op(0, 1, 32'hCAFE0000 + k, 1, 0, k[0], 11'(k * 7), 1);
    end
    repeat (10) doPop();
    check("t4.maxRec", maxRec <= 2, 1'b1);
    check("t4.empty", fifoEmpty, 1'b1);

    // Start while a record is open: error flag, first record lost, second kept.
    doStart();
    doLoad(32'h11111111);
    doLoad(32'h22222222);
    doStart();
    check("t5.err", fifoErr, 1'b1);
    doLoad(32'h33333333);
    doEnd(0, 11'd16);
    doPop();
    check("t5.hdrWord", fifoDataOut, 32'h00100001);
    doPop();
    check("t5.word", fifoDataOut, 32'h33333333);
    doClr();
    check("t5.errClr", fifoErr, 1'b0);

    // Record slot limit: 15 empty records fill the counter, the 16th is dropped.
    for (int k = 0; k < REC_MAX; k++) begin
      doStart();
      doEnd(1, 11'd5);
    end
    check("t6.recFull", fifoRecCnt, 4'd15);
    doStart();
    doEnd(0, 11'd5);
    check("t6.ovf", fifoOvf, 1'b1);
    check("t6.recStill", fifoRecCnt, 4'd15);
    doPop();
    check("t6.emptyHdr", fifoDataOut, 32'h80050000);
    repeat (REC_MAX - 1) doPop();
    check("t6.recDrained", fifoRecCnt, 4'd0);
    doClr();

    // Randomized traffic in phases of increasing host read rate.
    for (int i = 0; i < 3000; i++) begin
      readPct = (i < 1000) ? 10 : ((i < 2000) ? 60 : 95);
      r = $urandom_range(0, 99);
      wr_Start      = (r < 5);
      wr_Abort      = (r >= 5 && r < 8);
      wr_End        = (r >= 8 && r < 18);
      wr_Load       = (r >= 18 || wr_End) && ($urandom_range(0, 1) == 1);
      wr_Data       = $urandom;
      wr_Type       = $urandom_range(0, 1);
      wr_BitLen     = 11'($urandom_range(0, 2047));
      fifoRead      = ($urandom_range(0, 99) < readPct);
      fifoClrSticky = ($urandom_range(0, 49) == 0);
      cycle();
    end
    clearInputs();
    doAbort();
    repeat (DEPTH + 2) doPop();

    // Reset asserted with two records committed and a third open.
    for (int k = 0; k < 2; k++) begin
      doStart();
      doLoad($urandom);
      doEnd(0, 11'd16);
    end
    doStart();
    doLoad($urandom);
    check("t7.preRec", fifoRecCnt, 4'd2);
    Reset_n = 1'b0;
    #1;
    checkResetOutputs("t7.async");
    modelReset();
    @(negedge Clk);
    Reset_n = 1'b1;
    doPop();
    check("t7.emptyAfter", fifoEmpty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
